// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Byte distance between consecutive instruction addresses.
  localparam int unsigned PC_STEP = 4;

  // Opcode field position inside a fetched instruction.
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;

  // Reserved opcode that stops fetching.
  localparam logic [5:0] DEFAULT_HALT_OPCODE = 6'h3F;

  // Extract the opcode field from a 32-bit instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
`timescale 1ns/1ps
// Small prefetch FIFO holding {pc, instruction} entries.
// Power-of-two depth so read/write pointers wrap naturally.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full   = (r_count == L_DEPTH);
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign o_head   = r_mem[r_rd];

  // A push into a full FIFO is accepted only when a pop frees the slot.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  // Entry storage; cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// Instruction fetch sequencer: issues single-outstanding fetch requests,
// buffers responses in a prefetch FIFO, delivers them to the processor,
// follows branch redirects and stops on the reserved halt opcode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W      = 32,
  parameter int unsigned        DATA_W      = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter logic [5:0]         HALT_OPCODE = DEFAULT_HALT_OPCODE,
  parameter int unsigned        FIFO_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imemReqValid,
  output logic [ADDR_W-1:0] imemReqAddr,
  input  logic              imemReqReady,
  input  logic              imemRespValid,
  input  logic [DATA_W-1:0] imemRespData,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instrPc,
  output logic              instrValid,
  input  logic              instrReady,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectPc,
  output logic              busy,
  output logic              halted,
  output logic [31:0]       fetchCount
);

  localparam int unsigned       ENTRY_W   = ADDR_W + DATA_W;
  localparam int unsigned       CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] L_PC_STEP = ADDR_W'(PC_STEP);
  localparam logic [CNT_W-1:0]  L_DEPTH   = CNT_W'(FIFO_DEPTH);

  // Architectural state.
  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_outstanding;
  logic              r_drop_next;
  logic              r_redirect_gap;
  logic [31:0]       r_fetch_count;

  // FIFO interface.
  logic [ENTRY_W-1:0] w_head;
  logic [ADDR_W-1:0]  w_head_pc;
  logic [DATA_W-1:0]  w_head_instr;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;

  // Per-cycle control.
  logic w_in_fetch;
  logic w_head_halt;
  logic w_req_valid;
  logic w_accept;
  logic w_resp;
  logic w_instr_valid;
  logic w_deliver;
  logic w_push;
  logic w_flush;

  assign w_head_pc    = w_head[ENTRY_W-1:DATA_W];
  assign w_head_instr = w_head[DATA_W-1:0];

  assign w_in_fetch  = (r_state == FETCH);
  assign w_head_halt = w_in_fetch & ~w_fifo_empty
                       & (opcode_of(w_head_instr[31:0]) == HALT_OPCODE);

  // Request and delivery qualifiers depend only on registered state,
  // so no output has a combinational path from any input.
  assign w_req_valid   = w_in_fetch & ~r_outstanding & (w_fifo_count < L_DEPTH)
                         & ~w_head_halt & ~r_redirect_gap;
  assign w_accept      = w_req_valid & imemReqReady;
  assign w_resp        = imemRespValid & r_outstanding;
  assign w_instr_valid = w_in_fetch & ~w_fifo_empty & ~w_head_halt;
  assign w_deliver     = w_instr_valid & instrReady;

  // A response raced by a flush is still pushed; the flush wins inside the FIFO.
  assign w_push  = w_resp & w_in_fetch & ~r_drop_next & (~w_fifo_full | w_deliver);
  assign w_flush = w_in_fetch & (redirectValid | w_head_halt);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data ({r_req_pc, imemRespData}),
    .i_pop       (w_deliver),
    .i_flush     (w_flush),
    .o_head      (w_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty),
    .o_count     (w_fifo_count)
  );

  // Sequencer FSM: state, fetch PC, outstanding-request tracking and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_pc           <= RESET_PC;
      r_req_pc       <= '0;
      r_outstanding  <= 1'b0;
      r_drop_next    <= 1'b0;
      r_redirect_gap <= 1'b0;
      r_fetch_count  <= '0;
    end else begin
      r_redirect_gap <= 1'b0;

      if (w_deliver) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end

      // A response retires the outstanding request in any state, so a
      // late response after a halt cannot block the next run.
      if (w_resp) begin
        r_outstanding <= 1'b0;
        r_drop_next   <= 1'b0;
      end

      case (r_state)
        IDLE, HALTED: begin
          if (start) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
          end
        end

        FETCH: begin
          if (w_accept) begin
            r_outstanding <= 1'b1;
            r_req_pc      <= r_pc;
            r_pc          <= r_pc + L_PC_STEP;
          end
          // Redirect overrides the PC update above; a request still in
          // flight (or accepted now) must have its response discarded.
          if (redirectValid) begin
            r_pc           <= redirectPc;
            r_redirect_gap <= 1'b1;
            r_drop_next    <= w_accept | (r_outstanding & ~w_resp);
          end else if (w_head_halt) begin
            r_state     <= HALTED;
            r_drop_next <= r_outstanding & ~w_resp;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign imemReqValid = w_req_valid;
  assign imemReqAddr  = r_pc;
  assign instruction  = w_head_instr;
  assign instrPc      = w_head_pc;
  assign instrValid   = w_instr_valid;
  assign busy         = w_in_fetch;
  assign halted       = (r_state == HALTED);
  assign fetchCount   = r_fetch_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Directed bench for fetch_sequencer with a small behavioural instruction memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imemReqValid;
  logic [31:0] imemReqAddr;
  logic        imemReqReady;
  logic        imemRespValid = 1'b0;
  logic [31:0] imemRespData  = '0;
  logic [31:0] instruction;
  logic [31:0] instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        busy;
  logic        halted;
  logic [31:0] fetchCount;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Memory model state: one pending response, delivered mem_lat cycles late.
  int unsigned mem_lat   = 0;
  logic        pend      = 1'b0;
  int unsigned pend_cnt  = 0;
  logic [31:0] pend_addr = '0;

  fetch_sequencer #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'h3F),
    .FIFO_DEPTH  (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .imemReqValid  (imemReqValid),
    .imemReqAddr   (imemReqAddr),
    .imemReqReady  (imemReqReady),
    .imemRespValid (imemRespValid),
    .imemRespData  (imemRespData),
    .instruction   (instruction),
    .instrPc       (instrPc),
    .instrValid    (instrValid),
    .instrReady    (instrReady),
    .redirectValid (redirectValid),
    .redirectPc    (redirectPc),
    .busy          (busy),
    .halted        (halted),
    .fetchCount    (fetchCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2001_0005;
      32'h0000_0004: return 32'h2002_0007;
      32'h0000_000C: return 32'hFC00_0000;
      default:       return 32'h1000_0000 | a;
    endcase
  endfunction

  // Capture accepted requests on the rising edge, answer on a falling edge.
  always @(posedge clk or negedge clk) begin
    if (clk) begin
      if (imemReqValid && imemReqReady) begin
        pend      = 1'b1;
        pend_cnt  = mem_lat;
        pend_addr = imemReqAddr;
      end
    end else begin
      imemRespValid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          imemRespValid = 1'b1;
          imemRespData  = memval(pend_addr);
          pend          = 1'b0;
        end else begin
          pend_cnt = pend_cnt - 1;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_reqValid"}, 32'(imemReqValid), 32'd0);
    chk({tag, "_reqAddr"},  imemReqAddr,       32'd0);
    chk({tag, "_valid"},    32'(instrValid),   32'd0);
    chk({tag, "_instr"},    instruction,       32'd0);
    chk({tag, "_pc"},       instrPc,           32'd0);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_halted"},   32'(halted),       32'd0);
    chk({tag, "_count"},    fetchCount,        32'd0);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    start         = 1'b0;
    redirectValid = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    imemReqReady  = 1'b1;
    instrReady    = 1'b1;
    redirectValid = 1'b0;
    redirectPc    = '0;
    mem_lat       = 0;
    step();
    step();
    chk_reset_outputs("rst");
    rst_n = 1'b1;
    step();

    // Basic flow: two instructions at PCs 0 and 4, processor always ready.
    start = 1'b1;
    step();                                            // cycle 1
    start = 1'b0;
    chk("t1_busy",   32'(busy),         32'd1);
    chk("t1_req1",   32'(imemReqValid), 32'd1);
    chk("t1_addr0",  imemReqAddr,       32'h0);
    step();                                            // cycle 2
    chk("t1_req_wait", 32'(imemReqValid), 32'd0);
    chk("t1_nvalid2",  32'(instrValid),   32'd0);
    step();                                            // cycle 3
    chk("t1_valid3", 32'(instrValid),   32'd1);
    chk("t1_pc0",    instrPc,           32'h0);
    chk("t1_ins0",   instruction,       32'h2001_0005);
    chk("t1_addr4",  imemReqAddr,       32'h4);
    step();
    chk("t1_cnt1",   fetchCount,        32'd1);
    chk("t1_gap",    32'(instrValid),   32'd0);
    step();
    chk("t1_pc4",    instrPc,           32'h4);
    chk("t1_ins4",   instruction,       32'h2002_0007);
    step();
    chk("t1_cnt2",   fetchCount,        32'd2);

    // Backpressure fills the FIFO, then a redirect while PC 8 is in flight.
    do_reset();
    chk("t2_cnt_rst", fetchCount, 32'd0);
    instrReady = 1'b0;
    start      = 1'b1;
    step();                                            // S1
    start = 1'b0;
    chk("t2_addr0", imemReqAddr, 32'h0);
    step();                                            // S2
    step();                                            // S3
    chk("t2_pc0",    instrPc,           32'h0);
    chk("t2_addr4",  imemReqAddr,       32'h4);
    step();                                            // S4
    step();                                            // S5
    chk("t2_full_noreq", 32'(imemReqValid), 32'd0);
    chk("t2_hold_pc0",   instrPc,           32'h0);
    step();                                            // S6
    chk("t2_full_noreq2", 32'(imemReqValid), 32'd0);
    instrReady = 1'b1;
    step();                                            // S7
    chk("t2_pc4",    instrPc,           32'h4);
    chk("t2_ins4",   instruction,       32'h2002_0007);
    chk("t2_cnt1",   fetchCount,        32'd1);
    chk("t2_req8",   32'(imemReqValid), 32'd1);
    chk("t2_addr8",  imemReqAddr,       32'h8);
    mem_lat = 2;
    step();                                            // S8
    chk("t2_cnt2",   fetchCount,        32'd2);
    chk("t2_empty",  32'(instrValid),   32'd0);
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0100;
    step();                                            // S9
    redirectValid = 1'b0;
    mem_lat       = 0;
    chk("t3_gap_noreq", 32'(imemReqValid), 32'd0);
    chk("t3_addr100",   imemReqAddr,       32'h100);
    step();                                            // S10
    chk("t3_wait_old", 32'(imemReqValid), 32'd0);
    step();                                            // S11
    chk("t3_dropped",  32'(instrValid),   32'd0);
    chk("t3_req100",   32'(imemReqValid), 32'd1);
    chk("t3_addr100b", imemReqAddr,       32'h100);
    step();                                            // S12
    step();                                            // S13
    chk("t3_valid",  32'(instrValid), 32'd1);
    chk("t3_pc100",  instrPc,         32'h100);
    chk("t3_ins100", instruction,     32'h1000_0100);
    chk("t3_cnt",    fetchCount,      32'd2);

    // Halt opcode at PC 0xC, redirect ignored while halted, then restart.
    do_reset();
    instrReady = 1'b1;
    start      = 1'b1;
    step();                                            // H1
    start = 1'b0;
    repeat (6) step();                                 // H7
    chk("t4_pc8",      instrPc,           32'h8);
    step();                                            // H8
    step();                                            // H9
    chk("t4_nodeliver", 32'(instrValid),   32'd0);
    chk("t4_noreq",     32'(imemReqValid), 32'd0);
    chk("t4_headC",     instrPc,           32'hC);
    step();                                            // H10
    chk("t4_halted", 32'(halted),       32'd1);
    chk("t4_busy0",  32'(busy),         32'd0);
    chk("t4_cnt3",   fetchCount,        32'd3);
    chk("t4_noreq2", 32'(imemReqValid), 32'd0);
    redirectValid = 1'b1;
    redirectPc    = 32'h0000_0200;
    step();                                            // H11
    redirectValid = 1'b0;
    chk("t4_redir_ign", imemReqAddr,  32'h10);
    chk("t4_halted2",   32'(halted),  32'd1);
    start = 1'b1;
    step();                                            // H12
    start = 1'b0;
    chk("t4_restart_busy", 32'(busy),         32'd1);
    chk("t4_restart_req",  32'(imemReqValid), 32'd1);
    chk("t4_restart_addr", imemReqAddr,       32'h0);
    chk("t4_cnt_kept",     fetchCount,        32'd3);

    // Memory not ready for 5 cycles, then async reset mid-fetch.
    do_reset();
    imemReqReady = 1'b0;
    instrReady   = 1'b0;
    start        = 1'b1;
    step();                                            // W1
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t5_stall_valid", 32'(imemReqValid), 32'd1);
      chk("t5_stall_addr",  imemReqAddr,       32'h0);
      step();
    end                                                // W6
    imemReqReady = 1'b1;
    step();                                            // W7
    chk("t5_addr_plus4", imemReqAddr,       32'h4);
    chk("t5_outstanding", 32'(imemReqValid), 32'd0);
    step();                                            // W8
    chk("t6_one_entry", instrPc,           32'h0);
    chk("t6_valid",     32'(instrValid),   32'd1);
    chk("t6_req4",      32'(imemReqValid), 32'd1);
    mem_lat = 2;
    step();                                            // W9
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6_async");
    step();                                            // W10
    rst_n   = 1'b1;
    mem_lat = 0;
    step();                                            // W11
    step();                                            // W12
    chk("t6_late_ign", 32'(instrValid),   32'd0);
    chk("t6_idle",     32'(busy),         32'd0);
    chk("t6_noreq",    32'(imemReqValid), 32'd0);
    start = 1'b1;
    step();                                            // W13
    start = 1'b0;
    chk("t6_restart_req",  32'(imemReqValid), 32'd1);
    chk("t6_restart_addr", imemReqAddr,       32'h0);
    chk("t6_still_empty",  32'(instrValid),   32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Control block that sequences the processor datapath.
- Fetches instructions from instruction memory over a valid/ready request/response interface and buffers them in a small FIFO.
- Presents them one at a time on the processor's `instruction` input with a valid/ready handshake.
- Handles branch/jump redirects from the processor and halts on a reserved halt opcode.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- DATA_W, 32, instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset/start.
- HALT_OPCODE, 6'h3F, value of instruction[31:26] that stops fetching.
- FIFO_DEPTH, 2, prefetch buffer entries (power of two, ≥2).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetch from RESET_PC (honoured in IDLE or HALTED only).
- imemReqValid  out  1  fetch request valid.
- imemReqAddr  out  ADDR_W  fetch address.
- imemReqReady  in  1  memory accepts request.
- imemRespValid  in  1  response data valid (≥1 cycle after accept, in order).
- imemRespData  in  DATA_W  fetched instruction.
- instruction  out  DATA_W  instruction to processor.
- instrPc  out  ADDR_W  PC of `instruction`.
- instrValid  out  1  `instruction` valid.
- instrReady  in  1  processor consumes instruction.
- redirectValid  in  1  branch/jump taken.
- redirectPc  in  ADDR_W  new PC.
- busy  out  1  state is FETCH.
- halted  out  1  state is HALTED.
- fetchCount  out  32  instructions delivered, wraps mod 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, FIFO empty, outstanding=0, dropNext=0, fetchCount=0.
  - All outputs 0; instruction/instrPc/imemReqAddr read 0.
- States: IDLE, FETCH, HALTED.
  - IDLE --start--> FETCH.
  - FETCH --halt at FIFO head--> HALTED.
  - HALTED --start--> FETCH, with pc=RESET_PC and fetchCount preserved.
  - start in FETCH is ignored.
- Request issue:
  - In FETCH, imemReqValid=1 when outstanding=0, occupancy<FIFO_DEPTH, and not halting.
  - imemReqAddr=pc; both are registered.
  - On imemReqValid&imemReqReady: pc<=pc+4 (wraps mod 2^ADDR_W), outstanding<=1.
  - Address is held stable while valid and not ready, except on redirect.
- Response:
  - On imemRespValid with outstanding=1: outstanding<=0.
  - If dropNext=1: discard the response and clear dropNext.
  - Otherwise push {reqPc, data} into the FIFO.
  - Responses with outstanding=0, or in IDLE/HALTED, are ignored.
- Delivery:
  - instrValid=1 in FETCH when FIFO non-empty and the head opcode ≠ HALT_OPCODE.
  - instruction/instrPc come from the FIFO head.
  - Pop and increment fetchCount on instrValid&instrReady.
- Halt:
  - When the FIFO head opcode == HALT_OPCODE, the halt instruction is never delivered.
  - Next cycle: state=HALTED, FIFO flushed, and any outstanding response is dropped (dropNext=1).
- Redirect (priority over all else in FETCH):
  - A delivery handshake in the same cycle still counts (pop, count).
  - FIFO is flushed at end of cycle; pc<=redirectPc.
  - If a request is outstanding, or accepted this same cycle, set dropNext=1.
  - imemReqValid is deasserted for one cycle after the redirect, then reissues at redirectPc.
  - Redirect in IDLE/HALTED is ignored.
- Push and pop in the same cycle: occupancy unchanged, FIFO order preserved.
- Latency: with a zero-wait memory (ready=1, response 1 cycle after accept):
  - start at cycle 0 → imemReqValid at cycle 1 → instrValid at cycle 3.
  - Steady-state throughput is one instruction per 2 cycles (single outstanding request).
- rst_n asserted mid-operation: immediate return to reset values; the next rising edge after release samples normally.

Decomposition:
- fetch_pkg:
  - state enum {IDLE, FETCH, HALTED}.
  - PC_STEP=4.
  - OPCODE_MSB=31, OPCODE_LSB=26.
  - Default HALT_OPCODE.
- Sub-module fetch_fifo:
  - Parameterised depth, entries of {pc, instr}.
  - Ports push/pop/flush, full/empty, count.
  - Async active-low reset.

Test Plan:
- Reset then start, memory returns 0x2001_0005, 0x2002_0007 at PCs 0, 4, processor ready=1 → instrValid at cycle 3 with instrPc=0 then 4, fetchCount=2.
- Hold instrReady=0 → FIFO fills to 2, imemReqValid drops to 0, no data lost; release → instructions delivered in order 0, 4, then request for PC 8 issued.
- Redirect to 0x0000_0100 while a request for PC 8 is outstanding → PC 8 response discarded, FIFO empty, next request address 0x100, next delivered instrPc=0x100.
- Memory returns 0xFC00_0000 at PC 0xC → instrs at 0, 4, 8 delivered, halted=1, busy=0, fetchCount=3, no further requests; start → fetch resumes at RESET_PC.
- imemReqReady low for 5 cycles → imemReqAddr stable throughout; accept on 6th cycle, pc advances by exactly 4.
- rst_n low for 1 cycle mid-fetch with FIFO holding 1 entry → all outputs 0 immediately, state IDLE, late memory response ignored.
